// File: rtl/ga_pkg.sv
// Shared GA coprocessor types: request/response structs, operation codes and
// the issue-unit state and result records.
package ga_pkg;

   localparam int unsigned GA_MV_W           = 256;
   localparam int unsigned GA_REG_AW         = 5;
   localparam int unsigned GA_ISSUE_SCALAR_W = 32;

   typedef logic [GA_MV_W-1:0] ga_multivector_t;

   typedef enum logic [3:0] {
      GA_FUNCT_ADD   = 4'd0,
      GA_FUNCT_SUB   = 4'd1,
      GA_FUNCT_MUL   = 4'd2,
      GA_FUNCT_WEDGE = 4'd3,
      GA_FUNCT_DOT   = 4'd4,
      GA_FUNCT_REV   = 4'd5,
      GA_FUNCT_LOAD  = 4'd6,
      GA_FUNCT_STORE = 4'd7
   } ga_funct_e;

   typedef struct packed {
      logic                 valid;
      ga_funct_e            funct;
      logic [GA_REG_AW-1:0] ga_reg_a;
      logic [GA_REG_AW-1:0] ga_reg_b;
      logic [GA_REG_AW-1:0] rd_addr;
      logic                 we;
      logic                 use_ga_regs;
      ga_multivector_t      operand_a;
      ga_multivector_t      operand_b;
   } ga_req_t;

   typedef struct packed {
      logic            ready;
      logic            valid;
      ga_multivector_t result;
      logic            error;
      logic            overflow;
      logic            underflow;
   } ga_resp_t;

   typedef enum logic [1:0] {
      GA_ISSUE_IDLE  = 2'd0,
      GA_ISSUE_ISSUE = 2'd1,
      GA_ISSUE_WAIT  = 2'd2,
      GA_ISSUE_DONE  = 2'd3
   } ga_issue_state_e;

   typedef struct packed {
      logic [GA_ISSUE_SCALAR_W-1:0] data;
      logic                         error;
      logic                         timeout;
      logic                         overflow;
      logic                         underflow;
   } ga_issue_result_t;

   // A scalar operand occupies the low word of a multivector; all other blades are zero.
   function automatic ga_multivector_t ga_scalar_to_mv(input logic [GA_ISSUE_SCALAR_W-1:0] s);
      return ga_multivector_t'(s);
   endfunction

endpackage

// File: rtl/ga_issue_watchdog.sv
// Saturating cycle counter for the issue unit; strobes o_timeout on the last
// permitted cycle while enabled.
module ga_issue_watchdog
   import ga_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_timeout
);

   localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] SatCnt  = CntWidth'(TimeoutCycles);

   logic [CntWidth-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != SatCnt)) begin
         r_count <= r_count + CntWidth'(1);
      end
   end

   assign o_timeout = i_enable && (r_count == LastCnt);

endmodule

// File: rtl/ga_issue_unit.sv
// Initiator side of the GA request/response interface: issues one decoded
// instruction, waits for the response under a watchdog, returns the result.
module ga_issue_unit
   import ga_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  ga_funct_e                    issue_funct_i,
   input  logic [4:0]                   issue_ga_reg_a_i,
   input  logic [4:0]                   issue_ga_reg_b_i,
   input  logic [4:0]                   issue_rd_addr_i,
   input  logic                         issue_we_i,
   input  logic                         issue_use_ga_regs_i,
   input  logic [GA_ISSUE_SCALAR_W-1:0] issue_rs1_i,
   input  logic [GA_ISSUE_SCALAR_W-1:0] issue_rs2_i,
   output ga_req_t                      ga_req_o,
   input  ga_resp_t                     ga_resp_i,
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic [GA_ISSUE_SCALAR_W-1:0] result_data_o,
   output logic                         result_error_o,
   output logic                         result_timeout_o,
   output logic                         result_overflow_o,
   output logic                         result_underflow_o,
   output logic                         busy_o,
   output logic                         stale_resp_o
);

   localparam ga_issue_result_t TimeoutResult = '{
      data: '0, error: 1'b1, timeout: 1'b1, overflow: 1'b0, underflow: 1'b0
   };

   ga_issue_state_e  r_state;
   ga_req_t          r_req;
   ga_issue_result_t r_result;
   logic             r_issue_ready;
   logic             r_result_valid;
   logic             r_busy;
   logic             r_stale;

   ga_req_t          w_req_next;
   logic             w_accept;
   logic             w_wd_clear;
   logic             w_wd_enable;
   logic             w_timeout;
   logic             w_resp_unused;

   assign w_accept    = (r_state == GA_ISSUE_IDLE) && issue_valid_i;
   assign w_wd_clear  = w_accept || ((r_state == GA_ISSUE_ISSUE) && ga_resp_i.ready);
   assign w_wd_enable = (r_state == GA_ISSUE_ISSUE) || (r_state == GA_ISSUE_WAIT);

   // Only the low scalar word of the response result is returned to the core.
   assign w_resp_unused = ^ga_resp_i.result[GA_MV_W-1:GA_ISSUE_SCALAR_W];

   // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
   always_comb begin
      w_req_next             = '0;
      w_req_next.valid       = 1'b1;
      w_req_next.funct       = issue_funct_i;
      w_req_next.ga_reg_a    = GA_REG_AW'(issue_ga_reg_a_i);
      w_req_next.ga_reg_b    = GA_REG_AW'(issue_ga_reg_b_i);
      w_req_next.rd_addr     = GA_REG_AW'(issue_rd_addr_i);
      w_req_next.we          = issue_we_i;
      w_req_next.use_ga_regs = issue_use_ga_regs_i;
      if (!issue_use_ga_regs_i) begin
         w_req_next.operand_a = ga_scalar_to_mv(issue_rs1_i);
         w_req_next.operand_b = ga_scalar_to_mv(issue_rs2_i);
      end
   end

   ga_issue_watchdog #(
      .TimeoutCycles (TimeoutCycles),
      .CntWidth      (CntWidth)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_enable),
      .o_timeout (w_timeout)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state        <= GA_ISSUE_IDLE;
         r_req          <= '0;
         r_result       <= '0;
         r_issue_ready  <= 1'b1;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
         r_stale        <= 1'b0;
      end else begin
         if (ga_resp_i.valid && (r_state != GA_ISSUE_WAIT)) begin
            r_stale <= 1'b1;
         end
         case (r_state)
            GA_ISSUE_IDLE: begin
               if (w_accept) begin
                  r_req         <= w_req_next;
                  r_issue_ready <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= GA_ISSUE_ISSUE;
               end
            end
            GA_ISSUE_ISSUE: begin
               // A handshake on the final allowed cycle still counts as accepted.
               if (ga_resp_i.ready) begin
                  r_req.valid <= 1'b0;
                  r_state     <= GA_ISSUE_WAIT;
               end else if (w_timeout) begin
                  r_req.valid    <= 1'b0;
                  r_result       <= TimeoutResult;
                  r_result_valid <= 1'b1;
                  r_state        <= GA_ISSUE_DONE;
               end
            end
            GA_ISSUE_WAIT: begin
               if (ga_resp_i.valid) begin
                  r_result.data      <= ga_resp_i.result[GA_ISSUE_SCALAR_W-1:0];
                  r_result.error     <= ga_resp_i.error;
                  r_result.timeout   <= 1'b0;
                  r_result.overflow  <= ga_resp_i.overflow;
                  r_result.underflow <= ga_resp_i.underflow;
                  r_result_valid     <= 1'b1;
                  r_state            <= GA_ISSUE_DONE;
               end else if (w_timeout) begin
                  r_result       <= TimeoutResult;
                  r_result_valid <= 1'b1;
                  r_state        <= GA_ISSUE_DONE;
               end
            end
            GA_ISSUE_DONE: begin
               if (result_ready_i) begin
                  r_result_valid <= 1'b0;
                  r_issue_ready  <= 1'b1;
                  r_busy         <= 1'b0;
                  r_state        <= GA_ISSUE_IDLE;
               end
            end
            default: r_state <= GA_ISSUE_IDLE;
         endcase
      end
   end

   assign issue_ready_o      = r_issue_ready;
   assign ga_req_o           = r_req;
   assign result_valid_o     = r_result_valid;
   assign result_data_o      = r_result.data;
   assign result_error_o     = r_result.error;
   assign result_timeout_o   = r_result.timeout;
   assign result_overflow_o  = r_result.overflow;
   assign result_underflow_o = r_result.underflow;
   assign busy_o             = r_busy;
   assign stale_resp_o       = r_stale;

endmodule

// File: tb/tb_ga_issue_unit.sv
// Self-checking bench for ga_issue_unit: expected results are queued when an
// instruction is issued and compared when the unit presents its result.
module tb_ga_issue_unit;
   import ga_pkg::*;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   ga_funct_e   issue_funct = GA_FUNCT_ADD;
   logic [4:0]  issue_reg_a = '0;
   logic [4:0]  issue_reg_b = '0;
   logic [4:0]  issue_rd = '0;
   logic        issue_we = 1'b0;
   logic        issue_use = 1'b0;
   logic [31:0] issue_rs1 = '0;
   logic [31:0] issue_rs2 = '0;
   ga_req_t     ga_req;
   ga_resp_t    ga_resp = '0;
   logic        result_valid;
   logic        result_ready = 1'b0;
   logic [31:0] result_data;
   logic        result_error;
   logic        result_timeout;
   logic        result_overflow;
   logic        result_underflow;
   logic        busy;
   logic        stale_resp;

   int n_checks = 0;
   int n_errors = 0;
   ga_issue_result_t sb_q[$];

   ga_issue_unit #(.TimeoutCycles(TO)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .issue_valid_i      (issue_valid),
      .issue_ready_o      (issue_ready),
      .issue_funct_i      (issue_funct),
      .issue_ga_reg_a_i   (issue_reg_a),
      .issue_ga_reg_b_i   (issue_reg_b),
      .issue_rd_addr_i    (issue_rd),
      .issue_we_i         (issue_we),
      .issue_use_ga_regs_i(issue_use),
      .issue_rs1_i        (issue_rs1),
      .issue_rs2_i        (issue_rs2),
      .ga_req_o           (ga_req),
      .ga_resp_i          (ga_resp),
      .result_valid_o     (result_valid),
      .result_ready_i     (result_ready),
      .result_data_o      (result_data),
      .result_error_o     (result_error),
      .result_timeout_o   (result_timeout),
      .result_overflow_o  (result_overflow),
      .result_underflow_o (result_underflow),
      .busy_o             (busy),
      .stale_resp_o       (stale_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [255:0] ctrl_of(input ga_req_t r);
      return 256'({r.funct, r.ga_reg_a, r.ga_reg_b, r.rd_addr, r.we, r.use_ga_regs});
   endfunction

   function automatic logic [255:0] result_of_dut();
      return 256'({result_data, result_error, result_timeout, result_overflow, result_underflow});
   endfunction

   // One complete transaction. delay = cycles from the request pulse to the
   // response (0 = responder stays silent); stall = cycles with resp.ready low.
   task automatic run_op(input ga_funct_e f, input logic use_regs, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] rd, input logic we,
                         input logic [31:0] rs1, input logic [31:0] rs2, input int stall,
                         input int delay, input logic [31:0] rdata, input logic rerr,
                         input logic rov, input logic run, input int hold);
      ga_req_t          exp_req;
      ga_issue_result_t exp_res;
      ga_issue_result_t got_ref;
      int               waits;
      exp_req = '0;
      exp_req.valid = 1'b1;
      exp_req.funct = f;
      exp_req.ga_reg_a = ra;
      exp_req.ga_reg_b = rb;
      exp_req.rd_addr = rd;
      exp_req.we = we;
      exp_req.use_ga_regs = use_regs;
      if (!use_regs) begin
         exp_req.operand_a = {224'b0, rs1};
         exp_req.operand_b = {224'b0, rs2};
      end
      if (delay == 0) exp_res = '{data: 32'h0, error: 1'b1, timeout: 1'b1, overflow: 1'b0, underflow: 1'b0};
      else exp_res = '{data: rdata, error: rerr, timeout: 1'b0, overflow: rov, underflow: run};
      sb_q.push_back(exp_res);

      check("idle_issue_ready", 256'(issue_ready), 256'(1'b1));
      check("idle_busy", 256'(busy), 256'(1'b0));
      issue_valid = 1'b1; issue_funct = f; issue_reg_a = ra; issue_reg_b = rb; issue_rd = rd;
      issue_we = we; issue_use = use_regs; issue_rs1 = rs1; issue_rs2 = rs2;
      ga_resp.ready = (stall == 0);
      @(negedge clk);
      issue_valid = 1'b0;
      for (int k = 0; k <= stall; k++) begin
         ga_resp.ready = (k == stall);
         check("req_valid_issue", 256'(ga_req.valid), 256'(1'b1));
         check("req_ctrl", ctrl_of(ga_req), ctrl_of(exp_req));
         check("req_operand_a", ga_req.operand_a, exp_req.operand_a);
         check("req_operand_b", ga_req.operand_b, exp_req.operand_b);
         check("busy_issue", 256'(busy), 256'(1'b1));
         @(negedge clk);
      end
      check("req_valid_wait", 256'(ga_req.valid), 256'(1'b0));
      check("req_ctrl_hold", ctrl_of(ga_req), ctrl_of(exp_req));
      if (delay > 0) begin
         for (int i = 0; i < delay - 1; i++) begin
            check("no_result_early", 256'(result_valid), 256'(1'b0));
            check("busy_wait", 256'(busy), 256'(1'b1));
            @(negedge clk);
         end
         ga_resp.valid = 1'b1;
         ga_resp.result = {224'hDEAD, rdata};
         ga_resp.error = rerr;
         ga_resp.overflow = rov;
         ga_resp.underflow = run;
         @(negedge clk);
         ga_resp.valid = 1'b0;
         ga_resp.result = '0; ga_resp.error = 1'b0; ga_resp.overflow = 1'b0; ga_resp.underflow = 1'b0;
         check("result_latency", 256'(result_valid), 256'(1'b1));
      end else begin
         waits = 0;
         while (!result_valid && waits < 40) begin
            waits++;
            @(negedge clk);
         end
         check("timeout_wait_cycles", 256'(waits), 256'(TO));
      end
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 256'(1'b1), 256'(sb_q.size()));
      end else begin
         got_ref = sb_q.pop_front();
         check("result", result_of_dut(), 256'(got_ref));
         for (int h = 0; h < hold; h++) begin
            check("hold_valid", 256'(result_valid), 256'(1'b1));
            check("hold_result", result_of_dut(), 256'(got_ref));
            check("hold_issue_ready", 256'(issue_ready), 256'(1'b0));
            @(negedge clk);
         end
      end
      check("done_busy", 256'(busy), 256'(1'b1));
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("exit_result_valid", 256'(result_valid), 256'(1'b0));
      check("exit_issue_ready", 256'(issue_ready), 256'(1'b1));
      check("exit_busy", 256'(busy), 256'(1'b0));
   endtask

   initial begin
      #12;
      check("rst_issue_ready", 256'(issue_ready), 256'(1'b1));
      check("rst_req_zero", 256'(ga_req != '0), 256'(1'b0));
      check("rst_result_valid", 256'(result_valid), 256'(1'b0));
      check("rst_busy", 256'(busy), 256'(1'b0));
      check("rst_stale", 256'(stale_resp), 256'(1'b0));
      check("rst_result", result_of_dut(), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Register-operand ADD, response 4 cycles after the pulse.
      run_op(GA_FUNCT_ADD, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 32'h0, 32'h0, 0, 4, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 0);
      // Scalar MUL; operands land in the low word only.
      run_op(GA_FUNCT_MUL, 1'b0, 5'd1, 5'd2, 5'd7, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 0);
      // Coprocessor holds ready low for 3 cycles.
      run_op(GA_FUNCT_SUB, 1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 32'h0, 32'h0, 3, 3, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 0);
      // Silent responder: watchdog fires.
      run_op(GA_FUNCT_DOT, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0, 32'hAAAA_5555, 32'h1, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
      repeat (2) @(negedge clk);
      check("stale_before_late_resp", 256'(stale_resp), 256'(1'b0));
      ga_resp.valid = 1'b1;
      @(negedge clk);
      ga_resp.valid = 1'b0;
      check("stale_after_late_resp", 256'(stale_resp), 256'(1'b1));
      check("late_resp_ignored", 256'(result_valid), 256'(1'b0));
      run_op(GA_FUNCT_WEDGE, 1'b1, 5'd31, 5'd30, 5'd29, 1'b1, 32'h0, 32'h0, 1, 1, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 0);
      // Error and overflow flags with the core stalling the result for 5 cycles.
      run_op(GA_FUNCT_REV, 1'b0, 5'd2, 5'd3, 5'd4, 1'b1, 32'h0000_0010, 32'h0000_0020, 0, 5, 32'h0BAD_0BAD, 1'b1, 1'b1, 1'b0, 5);
      check("stale_sticky", 256'(stale_resp), 256'(1'b1));

      // Asynchronous reset while in WAIT.
      issue_valid = 1'b1; issue_funct = GA_FUNCT_LOAD; issue_use = 1'b0; issue_rs1 = 32'h7777_7777;
      issue_rs2 = 32'h1; issue_rd = 5'd6; issue_we = 1'b1;
      ga_resp.ready = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_wait_busy", 256'(busy), 256'(1'b1));
      check("pre_rst_req_fields", 256'(ga_req.operand_a), 256'(32'h7777_7777));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req_zero", 256'(ga_req != '0), 256'(1'b0));
      check("async_rst_issue_ready", 256'(issue_ready), 256'(1'b1));
      check("async_rst_busy", 256'(busy), 256'(1'b0));
      check("async_rst_stale", 256'(stale_resp), 256'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(GA_FUNCT_STORE, 1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 32'h0, 32'h0, 0, 2, 32'h1357_9BDF, 1'b0, 1'b0, 1'b1, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/ga_issue_unit.md
Name: ga_issue_unit

Overview:
- Initiator side of the GA request/response interface. Sits between the Ibex custom-instruction decode/EX stage and the GA coprocessor.
- Accepts one decoded GA instruction from the core, builds a `ga_req_t`, and issues it as a single-cycle pulse.
- Waits for `ga_resp_t.valid` under a timeout watchdog, then returns a 32-bit result plus status to the core over a valid/ready handshake.
- Single outstanding request; no reordering.

Parameters:
- TimeoutCycles, 1024, WAIT cycles before a timeout error is raised (must be >= 2).
- CntWidth, $clog2(TimeoutCycles+1), width of the watchdog counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- issue_valid_i  in  1  core offers an instruction.
- issue_ready_o  out  1  unit can accept an instruction.
- issue_funct_i  in  ga_funct_e  operation.
- issue_ga_reg_a_i  in  5  GA source register A.
- issue_ga_reg_b_i  in  5  GA source register B.
- issue_rd_addr_i  in  5  GA destination register.
- issue_we_i  in  1  write back into the GA register file.
- issue_use_ga_regs_i  in  1  1 = operands come from the GA register file, 0 = operands come from rs1/rs2.
- issue_rs1_i  in  32  scalar operand A.
- issue_rs2_i  in  32  scalar operand B.
- ga_req_o  out  ga_req_t  request to the coprocessor.
- ga_resp_i  in  ga_resp_t  response from the coprocessor.
- result_valid_o  out  1  result available to the core.
- result_ready_i  in  1  core consumes the result.
- result_data_o  out  32  low 32 bits of the response result.
- result_error_o  out  1  coprocessor error or timeout.
- result_timeout_o  out  1  error was caused by the watchdog.
- result_overflow_o  out  1  latched `resp.overflow`.
- result_underflow_o  out  1  latched `resp.underflow`.
- busy_o  out  1  state != IDLE.
- stale_resp_o  out  1  sticky: a response arrived while not in WAIT; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, except `issue_ready_o = 1`. `ga_req_o = '0`. State = IDLE, counter = 0, latched result and flags = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - `issue_ready_o = 1`.
  - On `issue_valid_i`: capture all fields into `req_q`, go to ISSUE.
  - `req_q` operand construction:
    - `use_ga_regs = 0`: `operand_a` = `issue_rs1_i` zero-extended into bits [31:0] of `ga_multivector_t`; `operand_b` likewise from `issue_rs2_i`.
    - `use_ga_regs = 1`: both operands = '0.
  - `ga_reg_a`, `ga_reg_b` and `rd_addr` are zero-extended to the package field widths.
- ISSUE
  - `ga_req_o = req_q` with `valid = 1`, for exactly the cycles in which `ga_resp_i.ready = 0`, plus the first cycle in which it is 1.
  - When `ga_resp_i.ready = 1`: go to WAIT, clear the counter.
  - The counter also runs in ISSUE; timeout can fire here.
- WAIT
  - `ga_req_o.valid = 0`, held 0 so the coprocessor can return to idle after write-back. Other `ga_req_o` fields hold `req_q`.
  - Counter increments each cycle.
  - When `ga_resp_i.valid = 1`:
    - latch `result[31:0]`, `error`, `overflow`, `underflow`;
    - `timeout = 0`;
    - go to DONE.
  - Else, when counter == TimeoutCycles-1:
    - latch `error = 1`, `timeout = 1`, `data = 0`, `overflow = 0`, `underflow = 0`;
    - go to DONE.
  - If `resp.valid` and timeout coincide, the response wins.
- DONE
  - `result_valid_o = 1`; all result outputs come from registers and are stable.
  - On `result_ready_i`: go to IDLE.
  - `issue_ready_o = 0`.
  - Back-to-back: a new instruction may be accepted in the cycle after DONE exits (IDLE), never in the same cycle.
- Latency (no stall): accept in cycle 0, req pulse in cycle 1, response at cycle N ≥ 2, `result_valid_o` at cycle N+1.
- `ga_resp_i.valid` seen in IDLE, ISSUE or DONE: ignored, and sets `stale_resp_o`. This covers a late response after a timeout.
- `busy_o` is asserted in ISSUE, WAIT and DONE.
- Reset mid-operation: immediate return to IDLE with all reset values; `ga_req_o.valid` drops asynchronously.
- Counter saturates and never wraps.

Decomposition:
- `ga_pkg` gains:
  - `ga_issue_state_e`;
  - `ga_issue_result_t` (data, error, timeout, overflow, underflow);
  - constant `GA_ISSUE_SCALAR_W = 32`.
- `ga_req_t`, `ga_resp_t` and `ga_funct_e` are reused unchanged.
- One sub-module: `ga_issue_watchdog` (counter, clear, enable, timeout strobe, saturation).

Test Plan:
- Basic ADD, register operands: `use_ga_regs=1`, reg_a=3, reg_b=4, rd=5, we=1, responder replies valid 4 cycles after the pulse with result low word 0x0000_00A5 → single-cycle `req.valid`; `result_valid_o` 1 cycle later; data=0xA5, error=0; `busy_o` high throughout.
- Scalar operands: MUL with rs1=0x1234_5678, rs2=0xFFFF_FFFF, `use_ga_regs=0` → `req.operand_a[31:0]=0x1234_5678` with upper bits 0; `operand_b[31:0]=0xFFFF_FFFF`.
- Ready stall: `resp.ready=0` for 3 cycles → `req.valid` held 4 cycles with fields stable; WAIT is entered only after ready=1.
- Timeout with TimeoutCycles=8, responder silent → DONE after 8 WAIT cycles with error=1, timeout=1, data=0. A response injected 2 cycles later sets `stale_resp_o=1`, and the next instruction completes normally.
- Error and flags: response with error=1, overflow=1 → `result_error_o=1`, `result_overflow_o=1`, `result_timeout_o=0`. With `result_ready_i` held low for 5 cycles, outputs stay stable and `issue_ready_o=0`.
- Async reset asserted in WAIT → `ga_req_o='0`, `issue_ready_o=1`, state IDLE, `stale_resp_o=0`.
